div_ctrl: RTL

Multi-cycle sequencer for RV32M division (DIV, DIVU, REM, REMU) attached to the execute stage.
- Accepts operands from the execute stage and runs a radix-2 restoring divider for 32 iterations.
- Handles RISC-V special cases (divide-by-zero, signed overflow).
- Raises a stall request to the pipeline controller until the result is valid.
- Supports flush-driven cancellation.

---
 rtl/div_ctrl_pkg.sv | 34 +++
 rtl/div_step.sv | 23 ++
 rtl/div_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared encodings for the RV32M division sequencer: op codes, FSM states,
// handshake constants and small op-decoding helpers.
package div_ctrl_pkg;

  // Division ops, extending the execute-stage AluOp set
  typedef enum logic [1:0] {
    EXE_DIV_OP  = 2'b00,
    EXE_DIVU_OP = 2'b01,
    EXE_REM_OP  = 2'b10,
    EXE_REMU_OP = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_ZERO = 3'd1,
    DIV_OVF  = 3'd2,
    DIV_CALC = 3'd3,
    DIV_DONE = 3'd4
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == EXE_DIV_OP) || (op == EXE_REM_OP);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == EXE_REM_OP) || (op == EXE_REMU_OP);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, trial-subtract the
// divisor from the upper W+1 bits, keep the difference if it did not borrow.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvsr_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);
  logic [W:0] w_part;
  logic [W:0] w_diff;
  logic       w_fits;

  // rem < divisor always, so the partial remainder needs only W+1 bits and
  // a borrow shows up in the top bit of the difference.
  assign w_part = {rem_i, quo_i[W-1]};
  assign w_diff = w_part - {1'b0, dvsr_i};
  assign w_fits = ~w_diff[W];
  assign rem_o  = w_fits ? w_diff[W-1:0] : w_part[W-1:0];
  assign quo_o  = {quo_i[W-2:0], w_fits};
endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle RV32M divide sequencer: accepts operands from execute, handles
// divide-by-zero and signed overflow directly, otherwise runs DATA_W restoring
// iterations, stalling the pipeline until the single-cycle ready pulse.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              cancel_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic              stallreq_o,
  output logic              busy_o,
  output logic              ready_o,
  output logic [DATA_W-1:0] result_o
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  div_state_e        r_state;
  div_op_e           r_op;
  logic [DATA_W-1:0] r_rem, r_quo, r_dvsr, r_result;
  logic              r_qneg, r_rneg, r_ready;
  logic [CNT_W-1:0]  r_cnt;

  div_op_e           w_op;
  logic              w_accept, w_sgn, w_a_neg, w_b_neg, w_ovf;
  logic [DATA_W-1:0] w_a_mag, w_b_mag, w_rem_nxt, w_quo_nxt, w_q_fix, w_r_fix;

  assign w_op     = div_op_e'(op_i);
  assign w_accept = (r_state == DIV_IDLE) & start_i & ~cancel_i;
  assign w_sgn    = op_is_signed(w_op);
  assign w_a_neg  = w_sgn & dividend_i[DATA_W-1];
  assign w_b_neg  = w_sgn & divisor_i[DATA_W-1];
  assign w_a_mag  = w_a_neg ? -dividend_i : dividend_i;
  assign w_b_mag  = w_b_neg ? -divisor_i : divisor_i;
  assign w_ovf    = w_sgn & (dividend_i == MIN_NEG) & (&divisor_i);

  div_step #(.W(DATA_W)) u_step (
    .rem_i  (r_rem),
    .quo_i  (r_quo),
    .dvsr_i (r_dvsr),
    .rem_o  (w_rem_nxt),
    .quo_o  (w_quo_nxt)
  );

  // Sign fixup applied to the final iteration's output on the way into DONE
  assign w_q_fix = r_qneg ? -w_quo_nxt : w_quo_nxt;
  assign w_r_fix = r_rneg ? -w_rem_nxt : w_rem_nxt;

  assign busy_o     = (r_state == DIV_ZERO) | (r_state == DIV_OVF) | (r_state == DIV_CALC);
  assign stallreq_o = w_accept | busy_o;
  assign ready_o    = r_ready;
  assign result_o   = r_result;

  // Sequencer FSM; reset beats cancel, cancel beats everything else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DIV_IDLE;
      r_op     <= EXE_DIV_OP;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_result <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_ready  <= DivResultNotReady;
      r_cnt    <= '0;
    end else begin
      r_ready <= DivResultNotReady;
      if (cancel_i && r_state != DIV_IDLE) begin
        r_state <= DIV_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          DIV_IDLE: if (w_accept) begin
            r_op   <= w_op;
            r_dvsr <= w_b_mag;
            r_qneg <= w_a_neg ^ w_b_neg;
            r_rneg <= w_a_neg;
            r_rem  <= '0;
            r_cnt  <= '0;
            if (divisor_i == '0) begin
              // Raw dividend kept: it is the remainder regardless of signedness
              r_quo   <= dividend_i;
              r_state <= DIV_ZERO;
            end else if (w_ovf) begin
              r_quo   <= w_a_mag;
              r_state <= DIV_OVF;
            end else begin
              r_quo   <= w_a_mag;
              r_state <= DIV_CALC;
            end
          end
          DIV_ZERO: begin
            r_result <= op_is_rem(r_op) ? r_quo : '1;
            r_ready  <= DivResultReady;
            r_state  <= DIV_DONE;
          end
          DIV_OVF: begin
            r_result <= op_is_rem(r_op) ? '0 : MIN_NEG;
            r_ready  <= DivResultReady;
            r_state  <= DIV_DONE;
          end
          DIV_CALC: begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(DATA_W - 1)) begin
              r_result <= op_is_rem(r_op) ? w_r_fix : w_q_fix;
              r_ready  <= DivResultReady;
              r_cnt    <= '0;
              r_state  <= DIV_DONE;
            end
          end
          default: r_state <= DIV_IDLE;
        endcase
      end
    end
  end
endmodule
